// File: rtl/prefetch_ar_arbiter_pkg.sv
// Shared types and constants for the prefetcher AR path: arbiter states,
// the AR payload record and the outstanding-burst ceiling.
package prefetcher_pkg;

  localparam int unsigned ADDR_BITS_DEF       = 16;
  localparam int unsigned BURST_LEN_WIDTH_DEF = 8;
  localparam int unsigned TID_WIDTH_DEF       = 8;

  typedef enum logic [1:0] {
    ARB,
    HOLD,
    FLUSH
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_BITS_DEF-1:0]       addr;
    logic [BURST_LEN_WIDTH_DEF-1:0] len;
    logic [TID_WIDTH_DEF-1:0]       id;
  } ar_payload_t;

  // Largest value the outstanding counter can hold (all ones).
  function automatic int unsigned max_outstanding(input int unsigned log_queue_size);
    return (32'd1 << (log_queue_size + 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/prefetch_ar_arbiter_if.sv
// AR request/grant bundle for the arbiter: demand and prefetch sources,
// the DRAM AR channel and the R-channel snoop.
interface prefetch_ar_arbiter_if #(
  parameter int unsigned ADDR_BITS       = 16,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TID_WIDTH       = 8
);
  logic                       d_ar_valid;
  logic                       d_ar_ready;
  logic [ADDR_BITS-1:0]       d_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] d_ar_len;
  logic [TID_WIDTH-1:0]       d_ar_id;

  logic                       p_ar_valid;
  logic                       p_ar_ready;
  logic [ADDR_BITS-1:0]       p_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] p_ar_len;
  logic [TID_WIDTH-1:0]       p_ar_id;

  logic                       m_ar_valid;
  logic                       m_ar_ready;
  logic [ADDR_BITS-1:0]       m_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] m_ar_len;
  logic [TID_WIDTH-1:0]       m_ar_id;

  logic                       m_r_valid;
  logic                       m_r_ready;
  logic                       m_r_last;

  // Arbiter side.
  modport slave (
    input  d_ar_valid, d_ar_addr, d_ar_len, d_ar_id,
    input  p_ar_valid, p_ar_addr, p_ar_len, p_ar_id,
    input  m_ar_ready, m_r_valid, m_r_ready, m_r_last,
    output d_ar_ready, p_ar_ready,
    output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id
  );

  // Requesters / DRAM side.
  modport master (
    output d_ar_valid, d_ar_addr, d_ar_len, d_ar_id,
    output p_ar_valid, p_ar_addr, p_ar_len, p_ar_id,
    output m_ar_ready, m_r_valid, m_r_ready, m_r_last,
    input  d_ar_ready, p_ar_ready,
    input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id
  );

endinterface

// File: rtl/prefetch_ar_arbiter_outstanding_tracker.sv
// Up/down counter of in-flight read bursts with a sticky underflow flag;
// simultaneous issue and completion leave the count unchanged.
module outstanding_tracker #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_count;
  logic             r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (r_count != '1) r_count <= r_count + CNT_W'(1);
    end else if (i_dec && !i_inc) begin
      if (r_count == '0) r_underflow <= 1'b1;
      else               r_count     <= r_count - CNT_W'(1);
    end
  end

  assign o_count     = r_count;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/prefetch_ar_arbiter.sv
// Single-AR-channel arbiter: strict-priority demand over throttled prefetch,
// registered AR output, and a flush that drains all outstanding bursts.
module prefetch_ar_arbiter
  import prefetcher_pkg::*;
#(
  parameter int unsigned ADDR_BITS         = 16,
  parameter int unsigned BURST_LEN_WIDTH   = 8,
  parameter int unsigned TID_WIDTH         = 8,
  parameter int unsigned LOG_QUEUE_SIZE    = 3,
  parameter int unsigned PRFETCH_FRQ_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  prefetch_ar_arbiter_if.slave         bus,
  input  logic                         flush,
  input  logic [LOG_QUEUE_SIZE:0]      crs_prOutstandingLimit,
  input  logic [PRFETCH_FRQ_WIDTH-1:0] crs_prefetch_freq,
  output logic [LOG_QUEUE_SIZE:0]      outstanding,
  output logic                         m_ar_is_prefetch,
  output logic                         flush_busy,
  output logic                         err_underflow
);

  localparam int unsigned     CNT_W   = LOG_QUEUE_SIZE + 1;
  localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(max_outstanding(LOG_QUEUE_SIZE));

  typedef struct packed {
    logic [ADDR_BITS-1:0]       addr;
    logic [BURST_LEN_WIDTH-1:0] len;
    logic [TID_WIDTH-1:0]       id;
  } ar_pay_t;

  arb_state_t                   r_state;
  arb_state_t                   w_next;
  logic                         r_flush_pend;
  ar_pay_t                      r_pay;
  logic                         r_is_pf;
  logic [PRFETCH_FRQ_WIDTH-1:0] r_ival;

  logic w_d_grant;
  logic w_p_grant;
  logic w_hold;
  logic w_m_hs;
  logic w_r_last_hs;

  assign w_hold      = (r_state == HOLD);
  assign w_m_hs      = w_hold && bus.m_ar_ready;
  assign w_r_last_hs = bus.m_r_valid && bus.m_r_ready && bus.m_r_last;

  always_comb begin
    w_next    = r_state;
    w_d_grant = 1'b0;
    w_p_grant = 1'b0;
    unique case (r_state)
      ARB: begin
        w_d_grant = bus.d_ar_valid && !r_flush_pend && (outstanding != OUT_MAX);
        w_p_grant = bus.p_ar_valid && !bus.d_ar_valid && !r_flush_pend &&
                    (outstanding < crs_prOutstandingLimit) &&
                    (r_ival >= crs_prefetch_freq);
        if (r_flush_pend)               w_next = FLUSH;
        else if (w_d_grant || w_p_grant) w_next = HOLD;
      end
      HOLD: begin
        if (bus.m_ar_ready) w_next = r_flush_pend ? FLUSH : ARB;
      end
      FLUSH: begin
        if (outstanding == '0) w_next = ARB;
      end
      default: w_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB;
      r_flush_pend <= 1'b0;
      r_pay        <= '0;
      r_is_pf      <= 1'b0;
      r_ival       <= '1;
    end else begin
      r_state <= w_next;

      // A new flush pulse wins over the drain-complete clear.
      if (flush)
        r_flush_pend <= 1'b1;
      else if (r_state == FLUSH && outstanding == '0)
        r_flush_pend <= 1'b0;

      if (w_d_grant) begin
        r_pay   <= '{addr: bus.d_ar_addr, len: bus.d_ar_len, id: bus.d_ar_id};
        r_is_pf <= 1'b0;
      end else if (w_p_grant) begin
        r_pay   <= '{addr: bus.p_ar_addr, len: bus.p_ar_len, id: bus.p_ar_id};
        r_is_pf <= 1'b1;
      end

      if (w_p_grant)        r_ival <= '0;
      else if (r_ival != '1) r_ival <= r_ival + PRFETCH_FRQ_WIDTH'(1);
    end
  end

  outstanding_tracker #(
    .CNT_W(CNT_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_m_hs),
    .i_dec      (w_r_last_hs),
    .o_count    (outstanding),
    .o_underflow(err_underflow)
  );

  assign bus.d_ar_ready = w_d_grant;
  assign bus.p_ar_ready = w_p_grant;
  assign bus.m_ar_valid = w_hold;
  assign bus.m_ar_addr  = r_pay.addr;
  assign bus.m_ar_len   = r_pay.len;
  assign bus.m_ar_id    = r_pay.id;

  assign m_ar_is_prefetch = r_is_pf;
  assign flush_busy       = r_flush_pend || (r_state == FLUSH);

endmodule
